best_readout_ctrl: RTL and testbench

- Address and readout controller for the 256-deep best-track circular buffer.
- Generates the buffer's write pointer, write enable, read address and protected-boundary address.
- Queues accepted L1As and streams each L1A's window of best-track words to the downstream DAQ packer through a valid/ready handshake.
- Sits between the trigger/L1A logic and the best-track memory on one side, and the readout packer on the other.

---
 rtl/best_readout_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_best_readout_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/best_readout_ctrl.sv
// -----------------------------------------------------------------------------
// best_readout_ctrl
//
// Address and readout controller for the best-track circular buffer.
// The write side runs a continuous time base (adw/we). Accepted L1As are
// turned into window start addresses and queued. A small FSM pops each start
// address, walks the window through the buffer read port, and streams the
// words to the DAQ packer over a valid/ready handshake. The protected
// boundary (adb) tells the memory which region must not be overwritten.
//
// Optional feature (macro BEST_RO_BXN_EN):
//   A 12-bit free-running BX counter is captured with every queued L1A. The
//   captured value is presented on l1a_bxn while dout_first is high, and is
//   0 otherwise. Without the macro there is no counter and no l1a_bxn port.
//
// Ports:
//   clk           in   system clock (40 MHz BX clock)
//   rst_n         in   asynchronous active-low reset
//   l1a           in   L1A accept strobe, one cycle
//   l1a_delay     in   latency (BX) from buffer write to L1A
//   wblock        in   window length in words (0 is treated as 1)
//   full          in   buffer-full flag from the memory
//   adw           out  buffer write address
//   we            out  buffer write enable
//   adr           out  buffer read address (data appears on dr next cycle)
//   adb           out  protected boundary: start of oldest unread window
//   dr            in   buffer read data
//   dout          out  readout word
//   dout_valid    out  dout holds a valid word
//   dout_first    out  first word of a window
//   dout_last     out  last word of a window
//   dout_ready    in   downstream accepts dout this cycle
//   l1a_bxn       out  BX number of the L1A (only with BEST_RO_BXN_EN)
//   l1a_overflow  out  one-cycle pulse: an L1A was dropped
// -----------------------------------------------------------------------------
module best_readout_ctrl #(
    parameter int AW     = 8,
    parameter int DW     = 34,
    parameter int QDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          l1a,
    input  logic [AW-1:0] l1a_delay,
    input  logic [AW-1:0] wblock,
    input  logic          full,
    output logic [AW-1:0] adw,
    output logic          we,
    output logic [AW-1:0] adr,
    output logic [AW-1:0] adb,
    input  logic [DW-1:0] dr,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_first,
    output logic          dout_last,
    input  logic          dout_ready,
`ifdef BEST_RO_BXN_EN
    output logic [11:0]   l1a_bxn,
`endif
    output logic          l1a_overflow
);

    localparam int QAW = $clog2(QDEPTH);
`ifdef BEST_RO_BXN_EN
    localparam int EW  = AW + 12;
`else
    localparam int EW  = AW;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Write side
    logic [AW-1:0] adw_q;
    logic          we_q;

    // Pending-L1A queue
    logic [EW-1:0] q_mem [QDEPTH];
    logic [QAW-1:0] q_wp_q;
    logic [QAW-1:0] q_rp_q;
    logic [QAW:0]   q_cnt_q;
    logic           q_empty;
    logic           q_full;
    logic           push;
    logic           pop;
    logic [EW-1:0]  entry_in;
    logic [EW-1:0]  head;
    logic [AW-1:0]  head_start;
    logic           ovf_q;

    // Readout FSM
    state_t         state_q;
    logic [AW-1:0]  ptr_q;
    logic [AW-1:0]  cnt_q;
    logic [AW-1:0]  win_start_q;
    logic           first_pend_q;
    logic           dr_vld_q;
    logic           xfer;
    logic           last_word;

    // Output register
    logic [DW-1:0]  dout_q;
    logic           dout_valid_q;
    logic           dout_first_q;
    logic           dout_last_q;

`ifdef BEST_RO_BXN_EN
    logic [11:0]    bx_q;
    logic [11:0]    head_bx;
    logic [11:0]    win_bx_q;
    logic [11:0]    l1a_bxn_q;
`endif

    // ------------------------------------------------------------------
    // Write side: we rises on the first clock after reset and stays up,
    // adw then advances every cycle with no stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q  <= 1'b0;
            adw_q <= '0;
        end else begin
            we_q <= 1'b1;
            if (we_q) begin
                adw_q <= adw_q + AW'(1);
            end
        end
    end

`ifdef BEST_RO_BXN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_q <= '0;
        end else begin
            bx_q <= bx_q + 12'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pending-L1A queue. A push into a full queue is still accepted when
    // the FSM pops in the same cycle.
    // ------------------------------------------------------------------
    assign q_empty = (q_cnt_q == '0);
    assign q_full  = (q_cnt_q == (QAW+1)'(QDEPTH));
    assign pop     = (state_q == S_LOAD);
    assign push    = l1a && !full && (!q_full || pop);
    assign head    = q_mem[q_rp_q];
    assign head_start = head[AW-1:0];

`ifdef BEST_RO_BXN_EN
    assign entry_in = {bx_q, adw_q - l1a_delay};
    assign head_bx  = head[AW+11:AW];
`else
    assign entry_in = adw_q - l1a_delay;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[q_wp_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_wp_q  <= '0;
            q_rp_q  <= '0;
            q_cnt_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                q_wp_q <= q_wp_q + QAW'(1);
            end
            if (pop) begin
                q_rp_q <= q_rp_q + QAW'(1);
            end
            case ({push, pop})
                2'b10:   q_cnt_q <= q_cnt_q + (QAW+1)'(1);
                2'b01:   q_cnt_q <= q_cnt_q - (QAW+1)'(1);
                default: q_cnt_q <= q_cnt_q;
            endcase
            ovf_q <= l1a && !push;
        end
    end

    // ------------------------------------------------------------------
    // Readout. ptr_q is the address whose word is on dr this cycle (once
    // dr_vld_q is set). adr is driven combinationally one ahead on a
    // transfer so the memory delivers the next word without a bubble, and
    // held on a stall so dr stays stable for the blocked word.
    // ------------------------------------------------------------------
    assign xfer      = (state_q == S_READ) && dr_vld_q && (!dout_valid_q || dout_ready);
    assign last_word = (cnt_q == AW'(1));
    assign adr       = xfer ? (ptr_q + AW'(1)) : ptr_q;

    always_comb begin
        if (state_q == S_READ || state_q == S_DONE) begin
            adb = win_start_q;
        end else if (!q_empty) begin
            adb = head_start;
        end else begin
            adb = adw_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            win_start_q  <= '0;
            first_pend_q <= 1'b0;
            dr_vld_q     <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_first_q <= 1'b0;
            dout_last_q  <= 1'b0;
`ifdef BEST_RO_BXN_EN
            win_bx_q     <= '0;
            l1a_bxn_q    <= '0;
`endif
        end else begin
            // Output register: load on transfer, clear flags once accepted
            if (xfer) begin
                dout_q       <= dr;
                dout_valid_q <= 1'b1;
                dout_first_q <= first_pend_q;
                dout_last_q  <= last_word;
`ifdef BEST_RO_BXN_EN
                l1a_bxn_q    <= first_pend_q ? win_bx_q : 12'd0;
`endif
            end else if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
                dout_first_q <= 1'b0;
                dout_last_q  <= 1'b0;
`ifdef BEST_RO_BXN_EN
                l1a_bxn_q    <= 12'd0;
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (!q_empty) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ptr_q        <= head_start;
                    win_start_q  <= head_start;
                    cnt_q        <= (wblock == '0) ? AW'(1) : wblock;
                    first_pend_q <= 1'b1;
                    dr_vld_q     <= 1'b0;
`ifdef BEST_RO_BXN_EN
                    win_bx_q     <= head_bx;
`endif
                    state_q      <= S_READ;
                end
                S_READ: begin
                    // dr carries the word for ptr_q from the second READ cycle on
                    dr_vld_q <= 1'b1;
                    if (xfer) begin
                        ptr_q        <= ptr_q + AW'(1);
                        cnt_q        <= cnt_q - AW'(1);
                        first_pend_q <= 1'b0;
                        if (last_word) begin
                            dr_vld_q <= 1'b0;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adw          = adw_q;
    assign we           = we_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign dout_first   = dout_first_q;
    assign dout_last    = dout_last_q;
    assign l1a_overflow = ovf_q;
`ifdef BEST_RO_BXN_EN
    assign l1a_bxn      = l1a_bxn_q;
`endif

endmodule

// File: tb/tb_best_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_best_readout_ctrl
//
// Scoreboard bench for best_readout_ctrl. Each L1A pushes its expected window
// words (from a fixed memory content function) into a queue; a monitor pops
// and compares on every accepted output word and checks that a stalled word
// is held. Directed stimulus covers write side, window reads, address wrap,
// queue overflow, back-pressure, single-word windows and reset mid-readout.
// -----------------------------------------------------------------------------
module tb_best_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l1a;
    logic [7:0]  l1a_delay;
    logic [7:0]  wblock;
    logic        full;
    logic [7:0]  adw;
    logic        we;
    logic [7:0]  adr;
    logic [7:0]  adb;
    logic [33:0] dr;
    logic [33:0] dout;
    logic        dout_valid;
    logic        dout_first;
    logic        dout_last;
    logic        dout_ready;
    logic        l1a_overflow;
`ifdef BEST_RO_BXN_EN
    logic [11:0] l1a_bxn;
`endif

    best_readout_ctrl #(.AW(8), .DW(34), .QDEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .l1a          (l1a),
        .l1a_delay    (l1a_delay),
        .wblock       (wblock),
        .full         (full),
        .adw          (adw),
        .we           (we),
        .adr          (adr),
        .adb          (adb),
        .dr           (dr),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_first   (dout_first),
        .dout_last    (dout_last),
        .dout_ready   (dout_ready),
`ifdef BEST_RO_BXN_EN
        .l1a_bxn      (l1a_bxn),
`endif
        .l1a_overflow (l1a_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [33:0] d;
        logic        f;
        logic        l;
        logic [11:0] bx;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   l1a_cyc = 0;

    // Buffer content: unique word per address
    function automatic logic [33:0] memf(input logic [7:0] a);
        return {a ^ 8'h5A, 18'h2AAAA, a};
    endfunction

    // Memory model: registered read port
    always @(posedge clk) dr <= memf(adr);

    always @(posedge clk) cyc <= cyc + 1;

    // Reference time base: write address and BX count
    logic [7:0]  exp_adw;
    logic        exp_we;
    logic [11:0] exp_bx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_adw <= 8'd0;
            exp_we  <= 1'b0;
            exp_bx  <= 12'd0;
        end else begin
            exp_we <= 1'b1;
            if (exp_we) exp_adw <= exp_adw + 8'd1;
            exp_bx <= exp_bx + 12'd1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compare accepted words and check hold during stalls
    logic        prev_stall = 1'b0;
    logic [35:0] prev_out;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", dout_valid, 1'b1);
                chk("hold_word", {dout, dout_first, dout_last}, prev_out);
            end
            if (dout_valid && dout_ready) begin
                acc_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", dout);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", dout, e.d);
                    chk("first", dout_first, e.f);
                    chk("last", dout_last, e.l);
`ifdef BEST_RO_BXN_EN
                    chk("l1a_bxn", l1a_bxn, e.bx);
`endif
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_out   = {dout, dout_first, dout_last};
        end
    end

    task automatic wait_adw(input logic [7:0] v);
        int t = 0;
        while (exp_adw != v && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk("wait_adw_timeout", (t < 600), 1'b1);
    endtask

    // Issue one L1A at the current negedge; expected words use the wblock
    // currently applied (it is held stable until the window drains).
    task automatic fire(input logic [7:0] dly, input logic drop);
        logic [7:0] st;
        int n;
        exp_t e;
        st = exp_adw - dly;
        n = (wblock == 8'd0) ? 1 : int'(wblock);
        l1a = 1'b1;
        l1a_delay = dly;
        l1a_cyc = cyc;
        if (!drop) begin
            for (int i = 0; i < n; i++) begin
                e.d  = memf(st + 8'(i));
                e.f  = (i == 0);
                e.l  = (i == n - 1);
                e.bx = (i == 0) ? exp_bx : 12'd0;
                sb.push_back(e);
            end
        end
        @(negedge clk);
        l1a = 1'b0;
        chk("l1a_overflow", l1a_overflow, drop);
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_drained"}, sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int span;
        rst_n = 1'b0;
        l1a = 1'b0;
        l1a_delay = 8'd0;
        wblock = 8'd1;
        full = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_adw", adw, 8'd0);
        chk("rst_we", we, 1'b0);
        chk("rst_adb", adb, 8'd0);
        chk("rst_dout", dout, 34'd0);
        chk("rst_valid", dout_valid, 1'b0);
        chk("rst_first_last", {dout_first, dout_last}, 2'b00);
        chk("rst_ovf", l1a_overflow, 1'b0);

        // Write side counting and wrap
        rst_n = 1'b1;
        @(negedge clk);
        chk("we_cycle1", we, 1'b1);
        chk("adw_cycle1", adw, 8'd0);
        @(negedge clk);
        chk("adw_cycle2", adw, 8'd1);
        chk("adb_idle", adb, 8'd1);
        repeat (254) @(negedge clk);
        chk("adw_255", adw, 8'd255);
        @(negedge clk);
        chk("adw_wrap", adw, 8'd0);
        chk("we_held", we, 1'b1);
        chk("adb_wrap", adb, 8'd0);

        // Basic window: adw=100, delay=20, 5 words from 80
        wblock = 8'd5;
        wait_adw(8'd100);
        acc_cyc.delete();
        fire(8'd20, 1'b0);
        chk("adb_queued", adb, 8'd80);
        repeat (3) @(negedge clk);
        chk("adb_reading", adb, 8'd80);
        drain("basic");
        chk("basic_count", acc_cyc.size(), 5);
        span = (acc_cyc.size() >= 5) ? acc_cyc[4] - acc_cyc[0] : -1;
        chk("basic_back_to_back", span, 4);
        span = (acc_cyc.size() >= 1) ? acc_cyc[0] - l1a_cyc : -1;
        chk("basic_latency", span, 5);
        chk("adb_after_done", adb, exp_adw);

        // Window wrapping 251..2
        wblock = 8'd8;
        wait_adw(8'd5);
        fire(8'd10, 1'b0);
        drain("wrap");

        // Queue overflow with the readout stalled
        wblock = 8'd2;
        dout_ready = 1'b0;
        acc_cyc.delete();
        for (int i = 0; i < 6; i++) fire(8'd3, (i == 5));
        @(negedge clk);
        chk("ovf_single_pulse", l1a_overflow, 1'b0);
        repeat (6) @(negedge clk);
        chk("stalled_valid", dout_valid, 1'b1);
        chk("stalled_no_accept", acc_cyc.size(), 0);
        dout_ready = 1'b1;
        drain("overflow");
        chk("overflow_words", acc_cyc.size(), 10);

        // full=1 drops the L1A
        full = 1'b1;
        fire(8'd3, 1'b1);
        full = 1'b0;
        repeat (8) @(negedge clk);
        chk("full_drop_idle", dout_valid, 1'b0);

        // Back-pressure pattern 1,0,0,1
        wblock = 8'd8;
        pat = 4'b1001;
        fire(8'd7, 1'b0);
        for (int i = 0; i < 40; i++) begin
            dout_ready = pat[i % 4];
            @(negedge clk);
        end
        dout_ready = 1'b1;
        drain("backpressure");

        // Single-word window (wblock=0), BX capture near counter wrap
        wblock = 8'd0;
`ifdef BEST_RO_BXN_EN
        begin
            int t = 0;
            while (exp_bx != 12'd4094 && t < 5000) begin
                @(negedge clk);
                t++;
            end
            chk("wait_bx_timeout", (t < 5000), 1'b1);
        end
`endif
        fire(8'd2, 1'b0);
        drain("single");

        // Reset during readout abandons the window
        wblock = 8'd8;
        dout_ready = 1'b0;
        fire(8'd4, 1'b0);
        repeat (8) @(negedge clk);
        chk("pre_reset_valid", dout_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", dout_valid, 1'b0);
        chk("midrst_last", dout_last, 1'b0);
        chk("midrst_adw", adw, 8'd0);
        chk("midrst_adb", adb, 8'd0);
        sb.delete();
        acc_cyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_idle", dout_valid, 1'b0);
        chk("post_reset_no_words", acc_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
